// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - square-wave note player with timed duration and silent gap
module tone_sequencer #(
    parameter int CLK_MHZ = 20,
    parameter int CNT_W   = 22,
    parameter int GAP_MS  = 20,
    parameter int MS_W    = 17
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [2:0] note_i,
    input  logic [1:0] octave_i,
    input  logic       rest_i,
    input  logic [7:0] dur_ms_i,
    input  logic       mute_i,
    output logic       speaker_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(CLK_MHZ * 1000 - 1);
    localparam logic [MS_W-1:0]  MS_ONE   = MS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       GAP_LAST = 8'((GAP_MS > 0) ? GAP_MS - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [MS_W-1:0]  pre_q, pre_d;
    logic [7:0]       ms_q, ms_d;
    logic [7:0]       dur_q, dur_d;
    logic             rest_q, rest_d;
    logic             tone_q, tone_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [10:0]      hp_us;
    logic [31:0]      hp_clk;
    logic [31:0]      hp_shift;
    logic             tick;

    // Half-period of each note in microseconds, C4..C5
    always_comb begin
        case (note_i)
            3'd0:    hp_us = 11'd1911;
            3'd1:    hp_us = 11'd1703;
            3'd2:    hp_us = 11'd1517;
            3'd3:    hp_us = 11'd1432;
            3'd4:    hp_us = 11'd1276;
            3'd5:    hp_us = 11'd1136;
            3'd6:    hp_us = 11'd1012;
            default: hp_us = 11'd956;
        endcase
    end

    assign hp_clk   = 32'(CLK_MHZ) * {21'd0, hp_us};
    assign hp_shift = hp_clk >> octave_i;
    assign tick     = (pre_q == MS_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        dur_d   = dur_q;
        rest_d  = rest_q;
        tone_d  = tone_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    limit_d = CNT_W'(hp_shift);
                    dur_d   = dur_ms_i;
                    rest_d  = rest_i;
                    cnt_d   = '0;
                    tone_d  = 1'b0;
                    pre_d   = '0;
                    ms_d    = '0;
                    if (dur_ms_i != 8'd0) begin
                        state_d = S_PLAY;
                    end else if (GAP_MS != 0) begin
                        state_d = S_GAP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_PLAY: begin
                if (cnt_q == limit_q - CNT_ONE) begin
                    cnt_d  = '0;
                    tone_d = ~tone_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                pre_d = tick ? '0 : pre_q + MS_ONE;
                if (tick) begin
                    if (ms_q == dur_q - 8'd1) begin
                        // Leaving PLAY: tone FF and counters restart clean
                        cnt_d  = '0;
                        tone_d = 1'b0;
                        ms_d   = '0;
                        if (GAP_MS != 0) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        ms_d = ms_q + 8'd1;
                    end
                end
            end

            S_GAP: begin
                pre_d = tick ? '0 : pre_q + MS_ONE;
                if (tick) begin
                    if (ms_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            dur_q   <= '0;
            rest_q  <= 1'b0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            dur_q   <= dur_d;
            rest_q  <= rest_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Mute is a live gate so it acts without waiting for a clock edge
    assign speaker_o = tone_q & (state_q == S_PLAY) & ~rest_q & ~mute_i;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - scoreboard bench for tone_sequencer output edges
module tb_tone_sequencer;

    localparam int CLK_MHZ = 1;
    localparam int GAP_MS  = 2;
    localparam int MS_CYC  = CLK_MHZ * 1000;
    localparam int GAP_CYC = GAP_MS * MS_CYC;

    typedef struct {
        int cyc;
        int kind;
        bit val;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] note;
    logic [1:0] octave;
    logic       rest;
    logic [7:0] dur;
    logic       mute;
    logic       speaker_o;
    logic       busy_o;
    logic       done_o;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ev_t  sb[$];
    int   hp_tab[8] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};
    int   mute_a_rel = -1;
    int   mute_b_rel = -1;
    int   abort_rel = 1 << 30;
    int   last_p0 = 0;
    int   last_done = 0;
    bit   end_req = 1'b0;
    bit   prev_b = 1'b0;
    bit   prev_s = 1'b0;
    bit   prev_d = 1'b0;

    tone_sequencer #(
        .CLK_MHZ(CLK_MHZ),
        .CNT_W  (22),
        .GAP_MS (GAP_MS),
        .MS_W   (17)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .note_i   (note),
        .octave_i (octave),
        .rest_i   (rest),
        .dur_ms_i (dur),
        .mute_i   (mute),
        .speaker_o(speaker_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void push(input int c, input int k, input bit v);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = 0;
        while (i < sb.size() && (sb[i].cyc * 4 + sb[i].kind) <= (c * 4 + k)) i++;
        sb.insert(i, e);
    endfunction

    // Expected output edges: value after edge t for busy(0), speaker(1), done(2)
    function automatic void build(input int p0, input int lim, input int d, input bit r);
        int tplay, tend, last, ma, mb, ab;
        bit b, s, dn, pb, ps, pd;
        tplay = p0 + d * MS_CYC;
        tend  = tplay + GAP_CYC;
        ma    = p0 + mute_a_rel;
        mb    = p0 + mute_b_rel;
        ab    = p0 + abort_rel;
        last  = (ab < tend + 1) ? ab : tend + 1;
        pb = 1'b0; ps = 1'b0; pd = 1'b0;
        for (int t = p0; t <= last; t++) begin
            if (t >= ab) begin
                b = 1'b0; s = 1'b0; dn = 1'b0;
            end else begin
                b  = (t < tend);
                dn = (t == tend);
                s  = (t < tplay) && ((((t - p0) / lim) % 2) == 1) && !r &&
                     !(t >= ma && t < mb);
            end
            if (b != pb) push(t, 0, b);
            if (s != ps) push(t, 1, s);
            if (dn != pd) push(t, 2, dn);
            pb = b; ps = s; pd = dn;
        end
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int n, input int o, input bit r, input int d);
        int p0;
        note   = 3'(n);
        octave = 2'(o);
        rest   = r;
        dur    = 8'(d);
        start  = 1'b1;
        p0 = cyc + 1;
        build(p0, (CLK_MHZ * hp_tab[n]) >> o, d, r);
        last_p0   = p0;
        last_done = p0 + d * MS_CYC + GAP_CYC;
        @(posedge clk);
        #1;
        start  = 1'b0;
        note   = 3'($urandom);
        octave = 2'($urandom);
        rest   = 1'($urandom);
        dur    = 8'($urandom);
    endtask

    task automatic take(input string tag, input int kind, input bit v);
        ev_t e;
        if (sb.size() == 0) begin
            check({tag, "_extra"}, cyc, -1);
        end else begin
            e = sb.pop_front();
            check({tag, "_cyc"}, cyc, e.cyc);
            check({tag, "_kind"}, kind, e.kind);
            check({tag, "_val"}, int'(v), int'(e.val));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) check("rst_outs", int'({speaker_o, busy_o, done_o}), 0);
        if (busy_o !== prev_b) begin
            take("busy", 0, busy_o);
            prev_b <= busy_o;
        end
        if (speaker_o !== prev_s) begin
            take("spk", 1, speaker_o);
            prev_s <= speaker_o;
        end
        if (done_o !== prev_d) begin
            take("done", 2, done_o);
            prev_d <= done_o;
        end
        if (end_req) begin
            check("sb_left", sb.size(), 0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        note   = 3'd0;
        octave = 2'd0;
        rest   = 1'b0;
        dur    = 8'd0;
        mute   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            note  = 3'(i);
            dur   = 8'd3;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        issue(0, 0, 1'b0, 5);
        wait_until(last_done + 10);
        issue(5, 2, 1'b0, 3);
        wait_until(last_done + 10);
        issue(2, 0, 1'b1, 4);
        wait_until(last_done + 10);

        mute_a_rel = 1000;
        mute_b_rel = 1500;
        issue(7, 0, 1'b0, 4);
        wait_until(last_p0 + 1000);
        mute = 1'b1;
        wait_until(last_p0 + 1500);
        mute = 1'b0;
        wait_until(last_p0 + 2500);
        start = 1'b1;
        note  = 3'd0;
        dur   = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(last_done + 10);
        mute_a_rel = -1;
        mute_b_rel = -1;

        abort_rel = 1500;
        issue(5, 2, 1'b0, 3);
        wait_until(last_p0 + 1500);
        rst_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort_rel = 1 << 30;
        repeat (3) @(posedge clk);
        #1;

        issue(3, 1, 1'b0, 2);
        wait_until(last_done);
        issue(1, 0, 1'b0, 0);
        wait_until(last_done + 10);
        end_req = 1'b1;
    end

endmodule
